// File: rtl/wb_stage.sv
// wb_stage: writeback pipeline register, result select, load alignment and retire counter
module wb_stage (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        ex_valid,
  input  logic        ex_flush,
  input  logic        ex_reg_wr,
  input  logic [4:0]  ex_rd,
  input  logic [1:0]  ex_wb_sel,
  input  logic [2:0]  ex_funct3,
  input  logic [31:0] ex_alu_result,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_csr_rdata,
  input  logic [31:0] mem_rdata,
  output logic        rf_enable,
  output logic [4:0]  rf_rd,
  output logic [31:0] rf_writedata,
  output logic        fwd_valid,
  output logic [4:0]  fwd_rd,
  output logic [31:0] fwd_data,
  output logic [31:0] instret
);
  logic        wb_valid;
  logic        reg_wr;
  logic [4:0]  rd;
  logic [1:0]  wb_sel;
  logic [2:0]  funct3;
  logic [31:0] alu_result;
  logic [31:0] pc;
  logic [31:0] csr_rdata;
  logic [31:0] instret_q;
  logic [7:0]  load_byte;
  logic [15:0] load_half;
  logic [31:0] load_data;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wb_valid   <= 1'b0;
      reg_wr     <= 1'b0;
      rd         <= 5'd0;
      wb_sel     <= 2'd0;
      funct3     <= 3'd0;
      alu_result <= 32'd0;
      pc         <= 32'd0;
      csr_rdata  <= 32'd0;
      instret_q  <= 32'd0;
    end else begin
      wb_valid   <= ex_valid & ~ex_flush;
      reg_wr     <= ex_reg_wr;
      rd         <= ex_rd;
      wb_sel     <= ex_wb_sel;
      funct3     <= ex_funct3;
      alu_result <= ex_alu_result;
      pc         <= ex_pc;
      csr_rdata  <= ex_csr_rdata;
      instret_q  <= instret_q + {31'd0, wb_valid};
    end
  end
  always_comb begin
    load_byte    = 8'(mem_rdata >> {alu_result[1:0], 3'b000});
    load_half    = alu_result[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data    = funct3 == 3'b000 ? {{24{load_byte[7]}}, load_byte} :
                   funct3 == 3'b100 ? {24'd0, load_byte} :
                   funct3 == 3'b001 ? {{16{load_half[15]}}, load_half} :
                   funct3 == 3'b101 ? {16'd0, load_half} : mem_rdata;
    rf_enable    = wb_valid & reg_wr & (rd != 5'd0);
    rf_rd        = rd;
    rf_writedata = wb_sel == 2'd0 ? alu_result :
                   wb_sel == 2'd1 ? load_data :
                   wb_sel == 2'd2 ? pc + 32'd4 : csr_rdata;
    fwd_valid    = rf_enable;
    fwd_rd       = rf_rd;
    fwd_data     = rf_writedata;
    instret      = instret_q;
  end
endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural model
module tb_wb_stage;
  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        ex_valid = 1'b0;
  logic        ex_flush = 1'b0;
  logic        ex_reg_wr = 1'b0;
  logic [4:0]  ex_rd = 5'd0;
  logic [1:0]  ex_wb_sel = 2'd0;
  logic [2:0]  ex_funct3 = 3'd0;
  logic [31:0] ex_alu_result = 32'd0;
  logic [31:0] ex_pc = 32'd0;
  logic [31:0] ex_csr_rdata = 32'd0;
  logic [31:0] mem_rdata = 32'd0;
  logic        rf_enable;
  logic [4:0]  rf_rd;
  logic [31:0] rf_writedata;
  logic        fwd_valid;
  logic [4:0]  fwd_rd;
  logic [31:0] fwd_data;
  logic [31:0] instret;
  int          errors = 0;
  int          checks = 0;
  logic [31:0] exp_instret = 32'd0;
  logic        pending = 1'b0;
  logic [31:0] base;
  logic        en_seen[4];
  wb_stage dut (
    .clock(clock), .reset_n(reset_n), .ex_valid(ex_valid), .ex_flush(ex_flush),
    .ex_reg_wr(ex_reg_wr), .ex_rd(ex_rd), .ex_wb_sel(ex_wb_sel), .ex_funct3(ex_funct3),
    .ex_alu_result(ex_alu_result), .ex_pc(ex_pc), .ex_csr_rdata(ex_csr_rdata),
    .mem_rdata(mem_rdata), .rf_enable(rf_enable), .rf_rd(rf_rd), .rf_writedata(rf_writedata),
    .fwd_valid(fwd_valid), .fwd_rd(fwd_rd), .fwd_data(fwd_data), .instret(instret)
  );
  always #5 clock = ~clock;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ref_wd(input logic [1:0] sel, input logic [2:0] f3,
                                         input logic [31:0] alu, pc, csr, mem);
    longint unsigned b, h;
    b = (longint'(mem) / (longint'(1) << (8 * alu[1:0]))) % 256;
    h = (longint'(mem) / (longint'(1) << (16 * (alu[1:0] / 2)))) % 65536;
    if (sel == 0) return alu;
    if (sel == 2) return 32'((longint'(pc) + 4) % (longint'(1) << 32));
    if (sel == 3) return csr;
    case (f3)
      3'b000: return b >= 128 ? 32'(b + 64'hFFFFFF00) : 32'(b);
      3'b100: return 32'(b);
      3'b001: return h >= 32768 ? 32'(h + 64'hFFFF0000) : 32'(h);
      3'b101: return 32'(h);
      default: return mem;
    endcase
  endfunction
  task automatic step(input string tag, input logic v, f, w, input logic [4:0] r,
                      input logic [1:0] sel, input logic [2:0] f3,
                      input logic [31:0] alu, pc, csr, mem, output logic en);
    ex_valid = v; ex_flush = f; ex_reg_wr = w; ex_rd = r; ex_wb_sel = sel;
    ex_funct3 = f3; ex_alu_result = alu; ex_pc = pc; ex_csr_rdata = csr;
    @(posedge clock);
    exp_instret = exp_instret + {31'd0, pending};
    pending = v & ~f;
    #1 mem_rdata = mem;
    #1;
    en = v && !f && w && r != 0;
    chk({tag, ".rf_enable"}, {31'd0, rf_enable}, {31'd0, en});
    chk({tag, ".fwd_valid"}, {31'd0, fwd_valid}, {31'd0, en});
    chk({tag, ".rf_rd"}, {27'd0, rf_rd}, {27'd0, r});
    chk({tag, ".fwd_rd"}, {27'd0, fwd_rd}, {27'd0, r});
    chk({tag, ".instret"}, instret, exp_instret);
    if (en) begin
      chk({tag, ".rf_writedata"}, rf_writedata, ref_wd(sel, f3, alu, pc, csr, mem));
      chk({tag, ".fwd_data"}, fwd_data, ref_wd(sel, f3, alu, pc, csr, mem));
    end
  endtask
  task automatic idle(input string tag);
    logic e;
    step(tag, 1'b0, 1'b0, 1'b0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, e);
  endtask
  initial begin
    logic e;
    #2;
    chk("reset.rf_enable", {31'd0, rf_enable}, 32'd0);
    chk("reset.fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("reset.instret", instret, 32'd0);
    chk("reset.rf_rd", {27'd0, rf_rd}, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    step("alu", 1, 0, 1, 5'd5, 2'd0, 3'd0, 32'h1234, 32'd0, 32'd0, 32'd0, e);
    chk("alu.data", rf_writedata, 32'h1234);
    step("x0", 1, 0, 1, 5'd0, 2'd0, 3'd0, 32'hFFFF, 32'd0, 32'd0, 32'd0, e);
    chk("alu.instret_after", instret, 32'd1);
    step("lb", 1, 0, 1, 5'd1, 2'd1, 3'b000, 32'h1002, 32'd0, 32'd0, 32'h80FF7F01, e);
    chk("x0.instret_after", instret, 32'd2);
    chk("lb.data", rf_writedata, 32'hFFFFFFFF);
    step("lbu", 1, 0, 1, 5'd2, 2'd1, 3'b100, 32'h1003, 32'd0, 32'd0, 32'h80FF7F01, e);
    chk("lbu.data", rf_writedata, 32'h00000080);
    step("lh", 1, 0, 1, 5'd3, 2'd1, 3'b001, 32'h1002, 32'd0, 32'd0, 32'h80FF7F01, e);
    chk("lh.data", rf_writedata, 32'hFFFF80FF);
    step("lhu", 1, 0, 1, 5'd4, 2'd1, 3'b101, 32'h1001, 32'd0, 32'd0, 32'h80FF7F01, e);
    chk("lhu.data", rf_writedata, 32'h00007F01);
    step("lw", 1, 0, 1, 5'd6, 2'd1, 3'b010, 32'h1003, 32'd0, 32'd0, 32'h80FF7F01, e);
    chk("lw.data", rf_writedata, 32'h80FF7F01);
    step("pc4", 1, 0, 1, 5'd7, 2'd2, 3'd0, 32'd0, 32'h100, 32'd0, 32'd0, e);
    chk("pc4.data", rf_writedata, 32'h104);
    step("pcwrap", 1, 0, 1, 5'd8, 2'd2, 3'd0, 32'd0, 32'hFFFFFFFC, 32'd0, 32'd0, e);
    chk("pcwrap.data", rf_writedata, 32'h0);
    step("csr", 1, 0, 1, 5'd9, 2'd3, 3'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'd0, e);
    chk("csr.data", rf_writedata, 32'hDEADBEEF);
    idle("drain");
    base = instret;
    for (int i = 0; i < 4; i++)
      step("stream", 1, i == 2, 1, 5'd10, 2'd0, 3'd0, 32'(i + 1), 32'd0, 32'd0, 32'd0, en_seen[i]);
    chk("stream.pattern", {28'd0, en_seen[0], en_seen[1], en_seen[2], en_seen[3]}, 32'b1101);
    idle("stream.drain");
    chk("stream.instret", instret - base, 32'd3);
    step("midrst", 1, 0, 1, 5'd11, 2'd0, 3'd0, 32'h55, 32'd0, 32'd0, 32'd0, e);
    #1 reset_n = 1'b0;
    #1;
    chk("midrst.rf_enable", {31'd0, rf_enable}, 32'd0);
    chk("midrst.fwd_valid", {31'd0, fwd_valid}, 32'd0);
    chk("midrst.instret", instret, 32'd0);
    exp_instret = 32'd0;
    pending = 1'b0;
    @(posedge clock);
    #1;
    chk("inrst.rf_enable", {31'd0, rf_enable}, 32'd0);
    chk("inrst.instret", instret, 32'd0);
    @(negedge clock);
    reset_n = 1'b1;
    idle("postrst");
    force dut.instret_q = 32'hFFFFFFFF;
    #1 release dut.instret_q;
    exp_instret = 32'hFFFFFFFF;
    step("wrap.retire", 1, 0, 0, 5'd0, 2'd0, 3'd0, 32'd0, 32'd0, 32'd0, 32'd0, e);
    idle("wrap.after");
    chk("wrap.instret", instret, 32'd0);
    for (int i = 0; i < 200; i++)
      step("rand", $urandom_range(3) != 0, $urandom_range(7) == 0, $urandom_range(1) == 1,
           5'($urandom_range(31)), 2'($urandom_range(3)), 3'($urandom_range(7)),
           $urandom, $urandom, $urandom, $urandom, e);
    idle("rand.drain");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/wb_stage.md
WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 The block SHALL have the ports listed below.
- clock  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- ex_valid  in  1  execute stage presents a valid instruction.
- ex_flush  in  1  kill the instruction presented this cycle.
- ex_reg_wr  in  1  instruction writes rd.
- ex_rd  in  5  destination register index.
- ex_wb_sel  in  2  result source: 0 ALU, 1 load, 2 PC+4, 3 CSR.
- ex_funct3  in  3  load type.
- ex_alu_result  in  32  ALU result; also the load byte address.
- ex_pc  in  32  instruction PC.
- ex_csr_rdata  in  32  CSR read value.
- mem_rdata  in  32  data-memory word, valid in the cycle the load occupies WB.
- rf_enable  out  1  register-file write enable.
- rf_rd  out  5  register-file write index.
- rf_writedata  out  32  register-file write data.
- fwd_valid  out  1  forwarding entry valid; equals rf_enable.
- fwd_rd  out  5  forwarding index; equals rf_rd.
- fwd_data  out  32  forwarding data; equals rf_writedata.
- instret  out  32  count of retired instructions.
REQ-002 The block SHALL use one clock, named clock, and an asynchronous active-low reset, named reset_n.

Function
REQ-003 The block SHALL hold one pipeline register: wb_valid, reg_wr, rd, wb_sel, funct3, alu_result, pc, and csr_rdata.
REQ-004 On each rising edge, the register SHALL capture all ex_* fields, with wb_valid <= ex_valid & ~ex_flush.
REQ-005 When ex_flush=1, wb_valid SHALL be 0 on the next cycle, whatever ex_valid is.
REQ-006 rf_enable SHALL be wb_valid & reg_wr & (rd != 0). It is combinational from registered state.
REQ-007 rf_rd SHALL be the registered rd.
REQ-008 Write latency SHALL be one cycle: an instruction presented in cycle N drives rf_* in cycle N+1 and is written at the edge ending N+1.
REQ-009 rf_writedata SHALL be selected by wb_sel:
- 0: alu_result.
- 1: aligned load data (REQ-010).
- 2: pc + 4, modulo 2^32 (0xFFFFFFFC -> 0x00000000).
- 3: csr_rdata.
REQ-010 Load alignment SHALL use off = alu_result[1:0]:
- LB (000): sign-extend byte mem_rdata[8*off+7 : 8*off].
- LBU (100): zero-extend the same byte.
- LH (001): sign-extend halfword mem_rdata[16*off[1]+15 : 16*off[1]]; off[0] ignored.
- LHU (101): zero-extend the same halfword.
- LW (010) and all other codes: full mem_rdata, offset ignored.
REQ-011 rf_writedata SHALL be driven even when rf_enable=0; its value then has no meaning.
REQ-012 fwd_valid, fwd_rd and fwd_data SHALL equal rf_enable, rf_rd and rf_writedata in the same cycle. They serve as the bypass for same-cycle register-file reads.
REQ-013 instret SHALL increment by 1 at each rising edge where wb_valid=1, including instructions with reg_wr=0 or rd=0.
REQ-014 instret SHALL wrap from 0xFFFFFFFF to 0x00000000.
REQ-015 Back-to-back valid instructions SHALL retire one per cycle with no bubbles.
REQ-016 Consecutive writes to the same rd SHALL each appear on rf_* in their own cycle.

Reset
REQ-017 While reset_n=0, the block SHALL hold wb_valid=0, all registered fields=0 and instret=0, independent of clock.
REQ-018 During reset, rf_enable and fwd_valid SHALL be 0.
REQ-019 An instruction presented in the cycle reset asserts SHALL be lost.
REQ-020 The first edge after reset_n rises SHALL capture normally.

Verification
REQ-021 The bench SHALL cover these directed scenarios:
- ALU write: ex_valid=1, rd=5, wb_sel=0, alu=0x1234 -> next cycle rf_enable=1, rf_rd=5, rf_writedata=0x1234; instret 0->1 at the following edge.
- x0 suppression: rd=0, reg_wr=1, alu=0xFFFF -> rf_enable=0 and fwd_valid=0; instret still increments.
- Loads with mem_rdata=0x80FF7F01:
  - LB off=2 -> 0xFFFFFFFF.
  - LBU off=3 -> 0x00000080.
  - LH off=2 -> 0xFFFF80FF.
  - LHU off=1 -> 0x00007F01.
  - LW off=3 -> 0x80FF7F01.
- PC+4 and CSR: wb_sel=2, pc=0x00000100 -> 0x00000104. wb_sel=2, pc=0xFFFFFFFC -> 0x00000000. wb_sel=3, csr=0xDEADBEEF -> 0xDEADBEEF.
- Flush and stream: 4 back-to-back valid instructions with ex_flush=1 on the 3rd -> rf_enable pattern 1,1,0,1 and instret=3.
- Reset mid-stream: reset_n=0 asynchronously while wb_valid=1 -> rf_enable=0 and instret=0 immediately, before the next edge. Force instret=0xFFFFFFFF and retire one instruction -> instret=0.
